rnd_stc_sched: RTL and testbench

RND_STC_SCHED -- requirements
Module: rnd_stc_sched

---
 rtl/rnd_stc_pkg.sv | 21 ++
 rtl/rnd_stc_rr_arb.sv | 43 ++++
 rtl/rnd_stc_sched.sv | 144 ++++++++++++++
 tb/tb_rnd_stc_sched.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnd_stc_pkg.sv
// rnd_stc_pkg: default datapath widths, latency and result record
// shared by the rnd_stc scheduler and its arbiter.
package rnd_stc_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH_I = 24;
  localparam int DEF_WIDTH_O = 4;
  localparam int DEF_LAT     = 2;
  localparam int DEF_TAG_W   = $clog2(DEF_N_REQ);

  typedef struct packed {
    logic [DEF_WIDTH_O-1:0] man;
    logic                   ofl;
    logic [DEF_TAG_W-1:0]   tag;
  } rnd_res_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rnd_stc_rr_arb.sv
// rnd_stc_rr_arb: one-hot round-robin arbiter; the search starts one
// past the last granted requester and the pointer moves only on a grant.
module rnd_stc_rr_arb
  import rnd_stc_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(ptr_q) + i) % N);
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
    ptr_d = found ? idx_o : ptr_q;
  end

  // Reset to N-1 so the first search lands on requester 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= IW'(N - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rnd_stc_sched.sv
// rnd_stc_sched: shares one rnd_stc datapath among N_REQ requesters.
// Define RND_STC_SCHED_STATS_EN to add the o_ofl_cnt overflow counter.
module rnd_stc_sched
  import rnd_stc_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int WIDTH_I = DEF_WIDTH_I,
  parameter  int WIDTH_O = DEF_WIDTH_O,
  parameter  int LAT     = DEF_LAT,
  parameter  int DEPTH   = LAT + 2,
  localparam int TW      = idx_w(N_REQ),
  localparam int PW      = idx_w(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req_vld,
  output logic [N_REQ-1:0]         o_req_rdy,
  input  logic [N_REQ*WIDTH_I-1:0] i_req_num,
  output logic [WIDTH_I-1:0]       o_dp_num,
  input  logic [WIDTH_O-1:0]       i_dp_man,
  input  logic                     i_dp_ofl,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [WIDTH_O-1:0]       o_man,
  output logic                     o_ofl,
  output logic [TW-1:0]            o_tag
`ifdef RND_STC_SCHED_STATS_EN
  ,
  output logic [15:0]              o_ofl_cnt
`endif
);

  logic [N_REQ-1:0]   gnt;
  logic [TW-1:0]      gnt_idx;
  logic               credit;
  logic               issue;
  logic               push;
  logic               pop;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic [PW-1:0]      wr_q, rd_q;
  logic [WIDTH_I-1:0] dp_num_q;
  logic [LAT-1:0]     pv_q;
  logic [TW-1:0]      pt_q [LAT];
  logic [WIDTH_O-1:0] man_q [DEPTH];
  logic [DEPTH-1:0]   ofl_q;
  logic [TW-1:0]      tag_q [DEPTH];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight and queued results, so the FIFO
  // can never be written while full.
  assign credit = cnt_q < CW'(DEPTH);

  rnd_stc_rr_arb #(
    .N (N_REQ)
  ) u_arb (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .req_i  (i_req_vld),
    .en_i   (credit & i_rst_n),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign o_req_rdy = gnt;
  assign issue     = |(gnt & i_req_vld);
  assign push      = pv_q[LAT-1];
  assign o_vld     = occ_q != '0;
  assign pop       = o_vld & i_rdy;
  assign cnt_d     = cnt_q + CW'(issue) - CW'(pop);
  assign occ_d     = occ_q + CW'(push) - CW'(pop);

  assign o_dp_num = dp_num_q;
  assign o_man    = o_vld ? man_q[rd_q] : '0;
  assign o_ofl    = o_vld & ofl_q[rd_q];
  assign o_tag    = o_vld ? tag_q[rd_q] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dp_num_q <= '0;
    end else if (issue) begin
      dp_num_q <= i_req_num[gnt_idx*WIDTH_I +: WIDTH_I];
    end
  end

  // Valid/tag shadow of the datapath; stage LAT-1 marks the cycle
  // in which i_dp_man/i_dp_ofl belong to that tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < LAT; i++) pt_q[i] <= '0;
    end else begin
      pv_q[0] <= issue;
      pt_q[0] <= gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      occ_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ofl_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        man_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      if (push) begin
        man_q[wr_q] <= i_dp_man;
        ofl_q[wr_q] <= i_dp_ofl;
        tag_q[wr_q] <= pt_q[LAT-1];
        wr_q        <= inc(wr_q);
      end
      if (pop) rd_q <= inc(rd_q);
    end
  end

`ifdef RND_STC_SCHED_STATS_EN
  logic [15:0] ofl_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ofl_cnt_q <= '0;
    end else if (pop && o_ofl && ofl_cnt_q != 16'hFFFF) begin
      ofl_cnt_q <= ofl_cnt_q + 16'd1;
    end
  end

  assign o_ofl_cnt = ofl_cnt_q;
`endif

endmodule

// File: tb/tb_rnd_stc_sched.sv
// tb_rnd_stc_sched: randomized bench for rnd_stc_sched against a queue
// reference of round-robin issue, credit limit and in-order results.
`timescale 1ns/1ps
module tb_rnd_stc_sched;
  import rnd_stc_pkg::*;

  localparam int N     = 4;
  localparam int WI    = 24;
  localparam int WO    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N-1:0]    req_rdy;
  logic [N*WI-1:0] req_num = '0;
  logic [WI-1:0]   dp_num;
  logic [WI-1:0]   dp_q;
  logic [WO-1:0]   dp_man;
  logic            dp_ofl;
  logic            vld;
  logic            rdy = 1'b0;
  logic [WO-1:0]   man;
  logic            ofl;
  logic [1:0]      tag;
`ifdef RND_STC_SCHED_STATS_EN
  logic [15:0]     ofl_cnt;
`endif

  int errs = 0;
  int checks = 0;
  int last_g = N - 1;
  int outst = 0;
  rnd_res_t expq[$];

  rnd_stc_sched #(
    .N_REQ(N), .WIDTH_I(WI), .WIDTH_O(WO), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_num(req_num),
    .o_dp_num(dp_num), .i_dp_man(dp_man), .i_dp_ofl(dp_ofl),
    .o_vld(vld), .i_rdy(rdy),
    .o_man(man), .o_ofl(ofl), .o_tag(tag)
`ifdef RND_STC_SCHED_STATS_EN
    , .o_ofl_cnt(ofl_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in rnd_stc: round to nearest on the top nibble, LAT=2.
  always @(posedge clk) dp_q <= dp_num;
  assign {dp_ofl, dp_man} = {1'b0, dp_q[23:20]} + {4'b0, dp_q[19]};

  function automatic rnd_res_t ref_res(input logic [WI-1:0] num, input int t);
    int s;
    s = int'(num[23:20]) + int'(num[19]);
    ref_res.man = WO'(s % 16);
    ref_res.ofl = s > 15;
    ref_res.tag = 2'(t);
  endfunction

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic rand_nums();
    for (int k = 0; k < N; k++) req_num[k*WI +: WI] = WI'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_vld = '1;
    rdy = 1'b1;
    #3;
    checks++;
    if ({req_rdy, vld, man, ofl, tag} !== '0) begin
      errs++;
      $display("FAIL reset_out: rdy=%b vld=%b man=%h ofl=%b tag=%0d want all 0",
               req_rdy, vld, man, ofl, tag);
    end
    checks++;
    if (dp_num !== '0) begin
      errs++;
      $display("FAIL reset_dp: o_dp_num=%h want 0", dp_num);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_vld = '0;
    last_g = N - 1;
    outst = 0;
    expq.delete();
  endtask

  task automatic test_single();
    int lat;
    rnd_res_t e;
    req_num = '0;
    req_num[WI-1:0] = 24'h123456;
    req_vld = 4'b0001;
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0001) begin
      errs++;
      $display("FAIL single_gnt: o_req_rdy=%b want 0001", req_rdy);
    end
    e = ref_res(24'h123456, 0);
    last_g = 0;
    @(posedge clk); #1;
    req_vld = '0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat != LAT + 1) begin
      errs++;
      $display("FAIL single_lat: latency=%0d want %0d", lat, LAT + 1);
    end
    checks++;
    if ({man, ofl, tag} !== {e.man, e.ofl, e.tag}) begin
      errs++;
      $display("FAIL single_res: man=%h ofl=%b tag=%0d want man=%h ofl=%b tag=%0d",
               man, ofl, tag, e.man, e.ofl, e.tag);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (vld !== 1'b0) begin
      errs++;
      $display("FAIL single_pop: o_vld=%b want 0", vld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rr();
    int g;
    logic [N-1:0] want;
    rnd_res_t e;
    rdy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      req_vld = (c < 16) ? '1 : '0;
      rand_nums();
      @(negedge clk);
      g = (c < 16) ? (last_g + 1) % N : -1;
      want = '0;
      if (g >= 0) want[g] = 1'b1;
      checks++;
      if (req_rdy !== want) begin
        errs++;
        $display("FAIL rr_gnt c=%0d: o_req_rdy=%b want %b", c, req_rdy, want);
      end
      if (vld && rdy) begin
        checks++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL rr_pop: o_vld=1 tag=%0d want o_vld=0", tag);
        end else begin
          e = expq.pop_front();
          outst--;
          if ({man, ofl, tag} !== {e.man, e.ofl, e.tag}) begin
            errs++;
            $display("FAIL rr_res: man=%h ofl=%b tag=%0d want man=%h ofl=%b tag=%0d",
                     man, ofl, tag, e.man, e.ofl, e.tag);
          end
        end
      end
      if (g >= 0) begin
        expq.push_back(ref_res(req_num[g*WI +: WI], g));
        last_g = g;
        outst++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL rr_drain: left=%0d want 0", expq.size());
    end
  endtask

  task automatic test_backpressure();
    int g;
    int issued;
    logic [N-1:0] want;
    rnd_res_t e;
    issued = 0;
    for (int c = 0; c < 40; c++) begin
      req_vld = (c < 26) ? '1 : '0;
      rdy = (c >= 20);
      rand_nums();
      @(negedge clk);
      g = (outst < DEPTH) ? rr_next(req_vld, last_g) : -1;
      want = '0;
      if (g >= 0) want[g] = 1'b1;
      checks++;
      if (req_rdy !== want) begin
        errs++;
        $display("FAIL bp_gnt c=%0d: o_req_rdy=%b want %b", c, req_rdy, want);
      end
      if (c < 20 && (req_rdy & req_vld) != '0) issued++;
      if (vld && rdy) begin
        checks++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL bp_pop: o_vld=1 tag=%0d want o_vld=0", tag);
        end else begin
          e = expq.pop_front();
          outst--;
          if ({man, ofl, tag} !== {e.man, e.ofl, e.tag}) begin
            errs++;
            $display("FAIL bp_res: man=%h ofl=%b tag=%0d want man=%h ofl=%b tag=%0d",
                     man, ofl, tag, e.man, e.ofl, e.tag);
          end
        end
      end
      if (g >= 0) begin
        expq.push_back(ref_res(req_num[g*WI +: WI], g));
        last_g = g;
        outst++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (issued != DEPTH) begin
      errs++;
      $display("FAIL bp_issues: issued=%0d want %0d", issued, DEPTH);
    end
    checks++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL bp_drain: left=%0d want 0", expq.size());
    end
  endtask

  task automatic test_reset_mid();
    int g;
    int stale;
    rnd_res_t e;
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_vld = '1;
      rand_nums();
      @(negedge clk);
      g = rr_next(req_vld, last_g);
      checks++;
      if (req_rdy !== N'(1 << g)) begin
        errs++;
        $display("FAIL rm_gnt c=%0d: o_req_rdy=%b want %b", c, req_rdy, N'(1 << g));
      end
      last_g = g;
      @(posedge clk); #1;
    end
    req_vld = '0;
    @(negedge clk);
    checks++;
    if (vld !== 1'b1) begin
      errs++;
      $display("FAIL rm_queued: o_vld=%b want 1", vld);
    end
    rst_n = 1'b0;
    req_vld = '1;
    #1;
    checks++;
    if ({req_rdy, vld, man, ofl, tag} !== '0) begin
      errs++;
      $display("FAIL rm_async: rdy=%b vld=%b man=%h ofl=%b tag=%0d want all 0",
               req_rdy, vld, man, ofl, tag);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_vld = '0;
    rdy = 1'b1;
    last_g = N - 1;
    outst = 0;
    expq.delete();
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vld !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin
      errs++;
      $display("FAIL rm_stale: stale_cycles=%0d want 0", stale);
    end
    req_vld = '1;
    rand_nums();
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0001) begin
      errs++;
      $display("FAIL rm_first: o_req_rdy=%b want 0001", req_rdy);
    end
    expq.push_back(ref_res(req_num[WI-1:0], 0));
    last_g = 0;
    @(posedge clk); #1;
    req_vld = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vld) begin
        checks++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL rm_pop: o_vld=1 tag=%0d want o_vld=0", tag);
        end else begin
          e = expq.pop_front();
          if ({man, ofl, tag} !== {e.man, e.ofl, e.tag}) begin
            errs++;
            $display("FAIL rm_res: man=%h ofl=%b tag=%0d want man=%h ofl=%b tag=%0d",
                     man, ofl, tag, e.man, e.ofl, e.tag);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL rm_drain: left=%0d want 0", expq.size());
    end
    outst = 0;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] want;
    rnd_res_t e;
    for (int c = 0; c < 320; c++) begin
      req_vld = (c < 300) ? N'($urandom_range(0, 15)) : '0;
      rdy = (c < 300) ? (($urandom % 4) != 0) : 1'b1;
      rand_nums();
      @(negedge clk);
      g = (outst < DEPTH) ? rr_next(req_vld, last_g) : -1;
      want = '0;
      if (g >= 0) want[g] = 1'b1;
      checks++;
      if (req_rdy !== want) begin
        errs++;
        $display("FAIL rnd_gnt c=%0d: o_req_rdy=%b want %b", c, req_rdy, want);
      end
      if (vld && rdy) begin
        checks++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL rnd_pop: o_vld=1 tag=%0d want o_vld=0", tag);
        end else begin
          e = expq.pop_front();
          outst--;
          if ({man, ofl, tag} !== {e.man, e.ofl, e.tag}) begin
            errs++;
            $display("FAIL rnd_res: man=%h ofl=%b tag=%0d want man=%h ofl=%b tag=%0d",
                     man, ofl, tag, e.man, e.ofl, e.tag);
          end
        end
      end
      if (g >= 0) begin
        expq.push_back(ref_res(req_num[g*WI +: WI], g));
        last_g = g;
        outst++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL rnd_drain: left=%0d want 0", expq.size());
    end
  endtask

`ifdef RND_STC_SCHED_STATS_EN
  task automatic test_ofl();
    logic [7:0] m;
    m = 8'hAD;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_g = N - 1;
    outst = 0;
    expq.delete();
    rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      req_vld = (c < 8) ? 4'b0001 : 4'b0000;
      if (c < 8)
        req_num[WI-1:0] = m[c] ? {4'hF, 1'b1, 19'($urandom)}
                               : {4'($urandom_range(0, 14)), 20'($urandom)};
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (ofl_cnt !== 16'd5) begin
      errs++;
      $display("FAIL ofl_cnt: o_ofl_cnt=%0d want 5", ofl_cnt);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef RND_STC_SCHED_STATS_EN
    test_ofl();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
